// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: byte FIFO feeding an 8N1 UART transmitter with AVR flow control.
// Bytes enter on a new_data strobe, leave as back-to-back frames on tx, and
// the block line is only honoured between frames so a frame is never cut short.
module serial_tx_fifo #(
    parameter int unsigned CLK_PER_BIT = 100,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_BITS    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          data,
    input  logic                new_data,
    output logic                busy,
    input  logic                block,
    output logic                tx,
    output logic [CNT_BITS-1:0] fifo_count,
    output logic                overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CYC_W = $clog2(CLK_PER_BIT);
    localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FIFO_DEPTH);
    localparam logic [2:0]          BIT_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             pop;

    // Full flag comes straight from the registered count; no bypass when full.
    assign busy  = (fifo_count == CNT_FULL);
    assign wr_en = new_data && !busy;

    // Byte storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CNT_BITS'(1);
                2'b01:   fifo_count <= fifo_count - CNT_BITS'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (new_data && busy) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flow-control synchronizer; resets to "blocked" so nothing leaves
    // until a clean deasserted level has been seen twice.
    // ------------------------------------------------------------------
    logic block_m;
    logic block_s;

    // Two-flop synchronizer for the asynchronous block input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_m <= 1'b1;
            block_s <= 1'b1;
        end else begin
            block_m <= block;
            block_s <= block_m;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_n;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shift;
    logic [7:0]       shift_n;
    logic             tx_n;
    logic             can_start;
    logic             cyc_done;

    assign can_start = (fifo_count != '0) && !block_s;
    assign cyc_done  = (cyc == CYC_LAST);

    // State, counters, shift register and the registered tx line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
        end
    end

    // Next-state logic; tx is derived from the next state so the line changes
    // on the same edge as the state register.
    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        tx_n      = 1'b1;

        case (state)
            IDLE: begin
                if (can_start) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    cyc_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cyc_done) begin
                    cyc_n     = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            DATA: begin
                if (cyc_done) begin
                    cyc_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == BIT_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            STOP: begin
                if (cyc_done) begin
                    cyc_n = '0;
                    if (can_start) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = '0;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: directed plus random stimulus against a queue-based
// model of the FIFO and an arithmetic model of the 8N1 line.
module tb_serial_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data = 8'h00;
    logic          new_data = 1'b0;
    logic          busy;
    logic          block = 1'b0;
    logic          tx;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    serial_tx_fifo #(
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .new_data  (new_data),
        .busy      (busy),
        .block     (block),
        .tx        (tx),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted bytes, position inside the current
    // frame (-1 = line idle), delayed copy of block, sticky overflow.
    bit [7:0] q_m[$];
    bit [7:0] sent_m[$];
    bit [7:0] cur_m = 8'h00;
    int       pos_m = -1;
    bit       b1_m = 1'b1;
    bit       b2_m = 1'b1;
    bit       ovf_m = 1'b0;

    function automatic void model_reset();
        q_m.delete();
        pos_m = -1;
        b1_m  = 1'b1;
        b2_m  = 1'b1;
        ovf_m = 1'b0;
    endfunction

    function automatic void model_step();
        bit full;
        bit go;
        full = (q_m.size() == DEPTH);
        go = 1'b0;
        if ((pos_m < 0 || pos_m == FRAME - 1) && q_m.size() != 0 && !b2_m)
            go = 1'b1;
        if (go) begin
            cur_m = q_m.pop_front();
            sent_m.push_back(cur_m);
            pos_m = 0;
        end else if (pos_m == FRAME - 1) begin
            pos_m = -1;
        end else if (pos_m >= 0) begin
            pos_m = pos_m + 1;
        end
        if (new_data) begin
            if (full) ovf_m = 1'b1;
            else q_m.push_back(data);
        end
        b2_m = b1_m;
        b1_m = block;
    endfunction

    function automatic int exp_tx();
        if (pos_m < 0) return 1;
        if (pos_m < CPB) return 0;
        if (pos_m < 9 * CPB) return int'(cur_m[(pos_m - CPB) / CPB]);
        return 1;
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model advances on every clock edge and on asynchronous reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("tx", int'(tx), exp_tx());
            check("fifo_count", int'(fifo_count), q_m.size());
            check("busy", int'(busy), int'(q_m.size() == DEPTH));
            check("overflow", int'(overflow), int'(ovf_m));
        end
    end

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (q_m.size() == 0 && pos_m < 0) done = 1'b1;
        end
        check("drain_timeout", int'(done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_sent(input string name, input bit [7:0] first, input int n);
        check({name, "_len"}, sent_m.size(), n);
        for (int i = 0; i < n && i < sent_m.size(); i++)
            check({name, "_byte"}, int'(sent_m[i]), int'(first) + i);
    endtask

    initial begin
        logic [9:0] frame;
        int         cnt_tab[7];
        int         ovf_tab[7];

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single 0xA5, literal frame shape
        frame = 10'b1_10100101_0;
        sent_m.delete();
        new_data = 1'b1;
        data = 8'hA5;
        @(posedge clk); #1;
        check("t1_count_e0", int'(fifo_count), 1);
        check("t1_tx_e0", int'(tx), 1);
        @(negedge clk);
        new_data = 1'b0;
        @(posedge clk); #1;
        check("t1_start", int'(tx), 0);
        check("t1_count_pop", int'(fifo_count), 0);
        for (int c = 1; c < FRAME; c++) begin
            @(posedge clk); #1;
            check("t1_frame", int'(tx), int'(frame[c / CPB]));
        end
        @(posedge clk); #1;
        check("t1_idle", int'(tx), 1);
        wait_drain();
        check_sent("t1_sent", 8'hA5, 1);

        // 2: three consecutive bytes, back-to-back frames
        cnt_tab = '{1, 1, 2, 0, 0, 0, 0};
        sent_m.delete();
        for (int i = 0; i < 3; i++) begin
            new_data = 1'b1;
            data = 8'(i + 1);
            @(posedge clk); #1;
            check("t2_count", int'(fifo_count), cnt_tab[i]);
            @(negedge clk);
        end
        new_data = 1'b0;
        wait_drain();
        check_sent("t2_sent", 8'h01, 3);

        // 3: seven strobes into a 4-deep FIFO
        cnt_tab = '{1, 1, 2, 3, 4, 4, 4};
        ovf_tab = '{0, 0, 0, 0, 0, 1, 1};
        sent_m.delete();
        for (int i = 0; i < 7; i++) begin
            new_data = 1'b1;
            data = 8'(8'h10 + i);
            @(posedge clk); #1;
            check("t3_count", int'(fifo_count), cnt_tab[i]);
            check("t3_ovf", int'(overflow), ovf_tab[i]);
            check("t3_busy", int'(busy), int'(cnt_tab[i] == 4));
            @(negedge clk);
        end
        new_data = 1'b0;
        wait_drain();
        check_sent("t3_sent", 8'h10, 5);
        check("t3_ovf_sticky", int'(overflow), 1);

        // 4: flow control
        sent_m.delete();
        block = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            new_data = 1'b1;
            data = 8'(8'h41 + i);
            @(negedge clk);
        end
        new_data = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_tx_held", int'(tx), 1);
        check("t4_count_held", int'(fifo_count), 2);
        block = 1'b0;
        @(posedge clk); #1;
        check("t4_rel_e1", int'(tx), 1);
        @(posedge clk); #1;
        check("t4_rel_e2", int'(tx), 1);
        @(posedge clk); #1;
        check("t4_rel_e3", int'(tx), 0);
        repeat (10) @(negedge clk);
        block = 1'b1;
        repeat (50) @(negedge clk);
        check("t4_second_held", int'(tx), 1);
        check("t4_count_one", int'(fifo_count), 1);
        check_sent("t4_sent_one", 8'h41, 1);
        block = 1'b0;
        wait_drain();
        check_sent("t4_sent", 8'h41, 2);

        // 5: asynchronous reset mid-DATA with 3 bytes queued
        sent_m.delete();
        for (int i = 0; i < 4; i++) begin
            new_data = 1'b1;
            data = 8'(8'h50 + i);
            @(negedge clk);
        end
        new_data = 1'b0;
        check("t5_queued", int'(fifo_count), 3);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_tx", int'(tx), 1);
        check("t5_rst_count", int'(fifo_count), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_ovf", int'(overflow), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sent_m.delete();
        repeat (60) @(negedge clk);
        check("t5_no_frames", sent_m.size(), 0);
        check("t5_line_idle", int'(tx), 1);

        // 6: pointer wrap, ten bytes in bursts of three
        sent_m.delete();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < ((b < 3) ? 3 : 1); i++) begin
                new_data = 1'b1;
                data = 8'(8'h30 + 3 * b + i);
                @(negedge clk);
            end
            new_data = 1'b0;
            wait_drain();
        end
        check_sent("t6_sent", 8'h30, 10);
        check("t6_ovf", int'(overflow), 0);

        // Random traffic and flow control
        for (int i = 0; i < 3000; i++) begin
            new_data = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            if ($urandom_range(0, 63) == 0) block = ~block;
            @(negedge clk);
        end
        new_data = 1'b0;
        block = 1'b0;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
